// File: rtl/eia608_pkg.sv
// eia608_pkg: shared types, constants and helpers for the line-21 caption packer
package eia608_pkg;
  localparam logic [15:0] NULL_PAIR = 16'h8080;
  typedef enum logic [1:0] {CLS_INVALID, CLS_BASIC, CLS_CONTROL, CLS_PAIR} cls_e;
  typedef enum logic {S_IDLE, S_EMIT} state_e;
  function automatic cls_e classify(input logic [15:0] w);
    return (w == 16'h0000) ? CLS_INVALID :
           (w[15:8] >= 8'h20 && w[15:8] <= 8'h7F && w[7:0] == 8'h00) ? CLS_BASIC :
           (w[15:8] >= 8'h10 && w[15:8] <= 8'h1F) ? CLS_CONTROL : CLS_PAIR;
  endfunction
  function automatic logic [7:0] odd_parity(input logic [6:0] b);
    return {~^b, b};
  endfunction
  function automatic logic [15:0] pair_parity(input logic [6:0] hi, input logic [6:0] lo);
    return {odd_parity(hi), odd_parity(lo)};
  endfunction
endpackage

// File: rtl/eia608_code_fifo.sv
// eia608_code_fifo: code-word FIFO exposing the two oldest entries, pops 0..2 per cycle
module eia608_code_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [15:0]                data_i,
  input  logic [1:0]                 pop_i,
  output logic [15:0]                head_o,
  output logic [15:0]                next_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign head_o  = mem_q[rd_q];
  assign next_o  = mem_q[rd_q + AW'(1)];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/eia608_cc_packer.sv
// eia608_cc_packer: buffers EIA-608 code words, emits one odd-parity byte pair per slot tick
// (define EIA608_CTRL_DOUBLE_EN to re-emit every control word on the following tick)
module eia608_cc_packer
  import eia608_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_stall,
  input  logic [15:0] in_data,
  input  logic        slot_tick,
  output logic        out_valid,
  input  logic        out_stall,
  output logic [15:0] out_data,
  output logic        overrun
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e        state_q, state_d;
  logic [15:0]   out_q, out_d, head, next, sel;
  logic          ovr_q, ovr_d, push, both, empty;
  logic [1:0]    sel_pop, pop_n;
  logic [CW-1:0] cnt;
  cls_e          head_cls, next_cls;
  eia608_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop_n),
    .head_o  (head),
    .next_o  (next),
    .count_o (cnt),
    .full_o  (in_stall)
  );
  // all-zero words are consumed but never stored
  assign push     = in_valid && !in_stall && classify(in_data) != CLS_INVALID;
  assign head_cls = classify(head);
  assign next_cls = classify(next);
  assign empty    = cnt == '0;
  assign both     = head_cls == CLS_BASIC && next_cls == CLS_BASIC && cnt >= CW'(2);
  assign sel_pop  = empty ? 2'd0 : both ? 2'd2 : 2'd1;
  assign sel      = empty ? NULL_PAIR :
                    both ? pair_parity(head[14:8], next[14:8]) :
                    head_cls == CLS_BASIC ? pair_parity(head[14:8], 7'h00) :
                    pair_parity(head[14:8], head[6:0]);
`ifdef EIA608_CTRL_DOUBLE_EN
  logic        rep_q, rep_d;
  logic [15:0] rep_word_q, rep_word_d;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep_q      <= 1'b0;
      rep_word_q <= '0;
    end else begin
      rep_q      <= rep_d;
      rep_word_q <= rep_word_d;
    end
  end
`endif
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pop_n   = 2'd0;
    ovr_d   = ovr_q | (slot_tick && state_q == S_EMIT);
`ifdef EIA608_CTRL_DOUBLE_EN
    rep_d      = rep_q;
    rep_word_d = rep_word_q;
`endif
    if (state_q == S_IDLE && slot_tick) begin
      state_d = S_EMIT;
      out_d   = sel;
      pop_n   = sel_pop;
`ifdef EIA608_CTRL_DOUBLE_EN
      if (rep_q) begin
        out_d = rep_word_q;
        pop_n = 2'd0;
        rep_d = 1'b0;
      end else if (!empty && head_cls == CLS_CONTROL) begin
        rep_d      = 1'b1;
        rep_word_d = sel;
      end
`endif
    end else if (state_q == S_EMIT && !out_stall) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end
  assign out_valid = state_q == S_EMIT;
  assign out_data  = out_q;
  assign overrun   = ovr_q;
endmodule

// File: doc/eia608_cc_packer.md
# eia608_cc_packer

Downstream of `eia608_from_utf8`: accepts the 16-bit EIA-608 code words that block returns and buffers them in a small FIFO. Once per caption-slot tick it emits exactly one line-21 byte pair with odd parity applied to each byte. Two basic characters are merged into one pair, and control codes go out alone. When nothing is queued it emits the null pair, so the caption channel stays continuously fed.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: code-word FIFO entries; power of two, 2..64.

Ports:
- `clock` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: code word present on `in_data`.
- `in_stall` output 1: FIFO full; the word is not accepted this cycle.
- `in_data` input 16: code word (`eia608_from_utf8` `returndata[15:0]`), high byte first.
- `slot_tick` input 1: single-cycle pulse, one per caption slot (field).
- `out_valid` output 1: byte pair on `out_data` is valid.
- `out_stall` input 1: sink not ready.
- `out_data` output 16: `{byte1, byte2}`, parity applied.
- `overrun` output 1: sticky; a `slot_tick` arrived while a pair was still pending.

## Operation
- **Classification** uses the raw word `w`:
  - `w==0x0000` is invalid. It is dropped at input (accepted, not stored).
  - basic: `w[15:8]` in 0x20..0x7F and `w[7:0]==0x00`.
  - control: `w[15:8]` in 0x10..0x1F.
  - anything else is a full pair and is emitted unmodified apart from parity.
- **Push rule:** push when `in_valid && !in_stall`.
- **Parity:** each output byte is `{~^b[6:0], b[6:0]}`. Incoming bit 7 is ignored.
- **Slot selection on `slot_tick`** (state IDLE):
  - `rep_pending` set: emit the saved control word again and clear `rep_pending`. No pop.
  - FIFO empty: emit null pair 0x8080.
  - Head basic and the entry behind it basic: pop both and emit `{head[15:8], next[15:8]}`.
  - Head basic otherwise (lone, or followed by non-basic): pop one and emit `{head[15:8], 0x00}`.
  - Head control or full pair: pop one and emit it.
- **States:**
  - IDLE → EMIT on `slot_tick`: `out_data` loaded, `out_valid`=1.
  - EMIT → IDLE when `!out_stall`.
  - `slot_tick` in EMIT sets `overrun` and is otherwise ignored. No pop, no queueing of the tick.
- **Pointers:** FIFO pointers wrap modulo `FIFO_DEPTH`. A count register of width `$clog2(FIFO_DEPTH)+1` distinguishes full from empty.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0x0000, `in_stall`=0, `overrun`=0. FIFO empty, state IDLE, `rep_pending`=0. Reset mid-slot discards everything, including a pending pair.
- **Latency:** `out_valid` rises the cycle after `slot_tick`. `out_data` is stable while `out_valid && out_stall`.
- **Input acceptance:** a word pushed in cycle N is visible to selection from N+1. A tick in the same cycle as the push does not see that word.
- **Full FIFO:** `in_stall` = (count==`FIFO_DEPTH`), registered. A pop in the same cycle as a full condition lowers `in_stall` the next cycle; push is not allowed on the popping cycle.
- **Simultaneous push and pop** when not full: count changes by +1−popped.
- **Throughput:** at most one pair per tick, two basic characters per pair.

## Configuration
- `EIA608_CTRL_DOUBLE_EN` defined: when a control word is emitted from the FIFO, `rep_pending` is set and the word is saved. The next tick re-emits it unchanged (CEA-608 redundant control transmission).
- Undefined: control words are emitted once, and `rep_pending` logic is absent.

## Structure
- **Package `eia608_pkg`:**
  - `NULL_PAIR` = 16'h8080.
  - class enum `{CLS_INVALID, CLS_BASIC, CLS_CONTROL, CLS_PAIR}`.
  - function `classify(w)`.
  - function `odd_parity(b)`.
  - FSM state enum `{S_IDLE, S_EMIT}`.
- **Sub-module `eia608_code_fifo`:** parameterised synchronous FIFO exposing head and head+1 entries and pop-1/pop-2.

## Test plan
- Reset, then three ticks with no input → 0x8080 three times. `in_stall`=0, `overrun`=0.
- Push 0x4800 ('H'), 0x6900 ('i'), then tick → single pair 0xC8E9. FIFO empty afterwards.
- Push 0x4800, then 0x1420, then two ticks:
  - 0xC880 then 0x9420.
  - With `EIA608_CTRL_DOUBLE_EN`, a third tick → 0x9420 again. Without it → 0x8080.
- Push `FIFO_DEPTH`+2 basic words back-to-back → `in_stall` high after 8 accepted. The next tick pops two and `in_stall` drops the following cycle.
- Hold `out_stall`=1 and issue two ticks → `out_data` stable and `overrun`=1 on the second. Release `out_stall` → one handshake only.
- Assert `resetn`=0 while in EMIT with a non-empty FIFO → all outputs return to reset values immediately. The next tick yields 0x8080.
